shfloat_scheduler: RTL and testbench

Round-robin scheduler that shares one `shfloat` I/Q packer between `CHANNELS` demodulator channels. Each cycle it grants at most one ready channel and issues that channel's index/I/Q sample to the packer. It tracks the packer's fixed pipeline latency so each packed word leaves tagged with its source channel. It also counts packed words into frames of `FRAME_LENGTH` words for the USB/stream framer downstream.

---
 rtl/shfloat_pkg.sv | 20 ++
 rtl/shfloat_scheduler_rr_arbiter.sv | 32 +++
 rtl/shfloat_scheduler.sv | 117 +++++++++++
 tb/tb_shfloat_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shfloat_pkg.sv
// Shared definitions for the shfloat packer and its channel scheduler:
// packer latency, packed-word field layout and the channel tag carried alongside words.
package shfloat_pkg;

  localparam int PACKER_LATENCY = 3;

  localparam int          MANT_W    = 12;
  localparam int          EXP_W     = 8;
  localparam logic [31:0] MANT_MASK = 32'hfff00000;

  // Wide enough for any realistic channel count; users slice down to their CH_W.
  localparam int TAG_CH_W = 8;
  typedef logic [TAG_CH_W-1:0] ch_tag_t;

  typedef struct packed {
    logic    vld;
    ch_tag_t ch;
  } tag_t;

endpackage

// File: rtl/shfloat_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from last+1 with wrap, grants the first
// requester as a one-hot vector plus its encoded index.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(last) + k) % N);
      if (en && !any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shfloat_scheduler.sv
// Round-robin scheduler sharing one shfloat I/Q packer between CHANNELS requesters;
// tags packer outputs with their source channel and marks frame boundaries.
module shfloat_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int INPUT_DEPTH    = 32,
  parameter int INDEX_DEPTH    = 32,
  parameter int PACKER_LATENCY = shfloat_pkg::PACKER_LATENCY,
  parameter int FRAME_LENGTH   = 64,
  parameter int CH_W           = $clog2(CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hold,
  input  logic [CHANNELS-1:0]             req_valid,
  output logic [CHANNELS-1:0]             req_ready,
  input  logic [CHANNELS*INDEX_DEPTH-1:0] req_index,
  input  logic [CHANNELS*INPUT_DEPTH-1:0] req_value_i,
  input  logic [CHANNELS*INPUT_DEPTH-1:0] req_value_q,
  output logic [INDEX_DEPTH-1:0]          pk_index,
  output logic [INPUT_DEPTH-1:0]          pk_value_i,
  output logic [INPUT_DEPTH-1:0]          pk_value_q,
  output logic                            pk_strobe,
  input  logic                            pk_done,
  output logic [CH_W-1:0]                 out_channel,
  output logic                            out_frame_end,
  output logic                            out_err
);

  import shfloat_pkg::*;

  localparam int              FC_W    = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LENGTH - 1);

  logic [CH_W-1:0]        last;
  logic [CH_W-1:0]        gnt_idx;
  logic                   gnt_any;
  logic [INDEX_DEPTH-1:0] sel_index;
  logic [INPUT_DEPTH-1:0] sel_i;
  logic [INPUT_DEPTH-1:0] sel_q;
  logic [CH_W-1:0]        pk_ch;
  tag_t                   tag_p [PACKER_LATENCY];
  logic [FC_W-1:0]        frame_cnt;
  logic                   unused_tag;

  rr_arbiter #(
    .N (CHANNELS),
    .W (CH_W)
  ) u_arb (
    .req  (req_valid),
    .last (last),
    .en   (!hold),
    .gnt  (req_ready),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  always_comb begin
    sel_index = '0;
    sel_i     = '0;
    sel_q     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (req_ready[c]) begin
        sel_index = req_index[c*INDEX_DEPTH +: INDEX_DEPTH];
        sel_i     = req_value_i[c*INPUT_DEPTH +: INPUT_DEPTH];
        sel_q     = req_value_q[c*INPUT_DEPTH +: INPUT_DEPTH];
      end
    end
  end

  // Issue stage: a grant always coincides with req_valid, so gnt_any marks a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= CH_W'(CHANNELS - 1);
      pk_strobe  <= 1'b0;
      pk_index   <= '0;
      pk_value_i <= '0;
      pk_value_q <= '0;
      pk_ch      <= '0;
    end else begin
      pk_strobe <= gnt_any;
      if (gnt_any) begin
        last       <= gnt_idx;
        pk_index   <= sel_index;
        pk_value_i <= sel_i;
        pk_value_q <= sel_q;
        pk_ch      <= gnt_idx;
      end
    end
  end

  // Tag pipe: mirrors the packer latency so the last stage aligns with pk_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < PACKER_LATENCY; s++) tag_p[s] <= '0;
    end else begin
      tag_p[0] <= '{vld: pk_strobe, ch: ch_tag_t'(pk_ch)};
      for (int s = 1; s < PACKER_LATENCY; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  assign out_channel = tag_p[PACKER_LATENCY-1].ch[CH_W-1:0];
  assign unused_tag  = ^tag_p[PACKER_LATENCY-1].ch;

  // Output stage: frame counting and sticky tag/strobe consistency check.
  assign out_frame_end = pk_done && (frame_cnt == FC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      out_err   <= 1'b0;
    end else begin
      if (pk_done) frame_cnt <= out_frame_end ? '0 : frame_cnt + 1'b1;
      if (pk_done != tag_p[PACKER_LATENCY-1].vld) out_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shfloat_scheduler.sv
// Directed bench for shfloat_scheduler with a queue-based reference model and a
// fixed-latency packer stand-in.
module tb_shfloat_scheduler;

  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int IW  = 32;
  localparam int LAT = 3;
  localparam int FL  = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [CH-1:0]     req_valid;
  logic [CH-1:0]     req_ready;
  logic [CH*IW-1:0]  req_index;
  logic [CH*DW-1:0]  req_value_i;
  logic [CH*DW-1:0]  req_value_q;
  logic [IW-1:0]     pk_index;
  logic [DW-1:0]     pk_value_i;
  logic [DW-1:0]     pk_value_q;
  logic              pk_strobe;
  logic              pk_done;
  logic [CW-1:0]     out_channel;
  logic              out_frame_end;
  logic              out_err;
  logic              inject;
  logic [LAT-1:0]    pk_sh;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shfloat_scheduler #(
    .CHANNELS       (CH),
    .INPUT_DEPTH    (DW),
    .INDEX_DEPTH    (IW),
    .PACKER_LATENCY (LAT),
    .FRAME_LENGTH   (FL),
    .CH_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_index     (req_index),
    .req_value_i   (req_value_i),
    .req_value_q   (req_value_q),
    .pk_index      (pk_index),
    .pk_value_i    (pk_value_i),
    .pk_value_q    (pk_value_q),
    .pk_strobe     (pk_strobe),
    .pk_done       (pk_done),
    .out_channel   (out_channel),
    .out_frame_end (out_frame_end),
    .out_err       (out_err)
  );

  // Packer stand-in: strobe emerges LAT cycles later, reset together with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) pk_sh <= '0;
    else     pk_sh <= {pk_sh[LAT-2:0], pk_strobe};
  end
  assign pk_done = pk_sh[LAT-1] | inject;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    int ch;
    int due;
  } ent_t;

  ent_t          fifo[$];
  int            cyc        = 0;
  int            m_last     = CH - 1;
  int            m_words    = 0;
  logic          m_strobe   = 1'b0;
  logic          m_err      = 1'b0;
  logic [IW-1:0] m_idx      = '0;
  logic [DW-1:0] m_i        = '0;
  logic [DW-1:0] m_q        = '0;
  int            fe_count   = 0;
  int            done_count = 0;

  always @(negedge clk) begin
    int            g;
    logic [CH-1:0] er;
    logic          due;
    int            c;
    cyc++;
    if (rst) begin
      m_last = CH - 1; m_strobe = 1'b0; m_err = 1'b0; m_words = 0;
      m_idx = '0; m_i = '0; m_q = '0;
      fifo.delete();
    end
    g  = -1;
    er = '0;
    if (!hold) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("pk_strobe", 64'(pk_strobe), 64'(m_strobe));
    chk("pk_index", 64'(pk_index), 64'(m_idx));
    chk("pk_value_i", 64'(pk_value_i), 64'(m_i));
    chk("pk_value_q", 64'(pk_value_q), 64'(m_q));
    chk("out_err", 64'(out_err), 64'(m_err));
    due = (fifo.size() > 0) && (fifo[0].due == cyc);
    if (due && pk_done) chk("out_channel", 64'(out_channel), 64'(fifo[0].ch));
    if (rst) chk("out_channel_rst", 64'(out_channel), 64'd0);
    chk("out_frame_end", 64'(out_frame_end), 64'(pk_done && (m_words % FL == FL - 1)));
    if (pk_done) begin
      m_words++;
      done_count++;
    end
    if (out_frame_end) fe_count++;
    if (!rst) begin
      if (pk_done != due) m_err = 1'b1;
      if (due) void'(fifo.pop_front());
      if (g >= 0) begin
        m_last   = g;
        m_strobe = 1'b1;
        m_idx    = req_index[g*IW +: IW];
        m_i      = req_value_i[g*DW +: DW];
        m_q      = req_value_q[g*DW +: DW];
        fifo.push_back('{ch: g, due: cyc + 1 + LAT});
      end else begin
        m_strobe = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int fe0;
    int d0;
    rst = 1'b1; hold = 1'b0; req_valid = '0; inject = 1'b0;
    for (int c = 0; c < CH; c++) begin
      req_index[c*IW +: IW]   = 32'h100 + c;
      req_value_i[c*DW +: DW] = 32'h1000 + c;
      req_value_q[c*DW +: DW] = 32'h2000 + c;
    end
    tick(); tick();
    mid();
    chk("rst_pk_strobe", 64'(pk_strobe), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_frame_end", 64'(out_frame_end), 64'd0);
    tick();
    rst = 1'b0;

    // All channels valid: strict rotation starting at channel 0
    req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk("s1_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("s1_pk_index", 64'(pk_index), 64'(32'h100 + (k - 1) % 4));
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Lone requester granted back-to-back
    req_index[2*IW +: IW] = 32'h55;
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("s2_grant", 64'(req_ready), 64'(4'b0100));
      if (k > 0) chk("s2_pk_index", 64'(pk_index), 64'h55);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Channels 1 and 3 with last=1: alternate 3,1,3,...
    req_valid = 4'b0010;
    mid();
    chk("s3_prime", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("s3_grant", 64'(req_ready), (k % 2 == 0) ? 64'(4'b1000) : 64'(4'b0010));
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // 10 words into a frame counter aligned at 0: ends on words 4 and 8
    fe0 = fe_count;
    req_valid = 4'b0001;
    repeat (10) tick();
    req_valid = '0;
    repeat (6) tick();
    chk("frame_end_count", 64'(fe_count - fe0), 64'd2);
    req_valid = 4'b0001;
    repeat (2) tick();
    req_valid = '0;
    repeat (6) tick();
    chk("frame_tail", 64'(fe_count - fe0), 64'd3);

    // Hold mid-burst: no grant that cycle, only in-flight words emerge
    req_valid = 4'hf;
    repeat (3) tick();
    hold = 1'b1;
    d0 = done_count;
    mid();
    chk("hold_ready", 64'(req_ready), 64'd0);
    repeat (8) tick();
    chk("hold_drain", 64'(done_count - d0), 64'd3);
    chk("hold_err", 64'(out_err), 64'd0);
    hold = 1'b0;
    req_valid = '0;
    repeat (6) tick();

    // Spurious packer output sets the sticky error
    inject = 1'b1;
    tick();
    inject = 1'b0;
    mid();
    chk("inject_err", 64'(out_err), 64'd1);
    repeat (3) tick();
    mid();
    chk("inject_sticky", 64'(out_err), 64'd1);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_err", 64'(out_err), 64'd0);
    chk("async_rst_strobe", 64'(pk_strobe), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 4'hf;
    mid();
    chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
